// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer, valid/ready handshake,
// synchronous flush and NOP (all-zero) output whenever no entry is presented.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] h_data, h_data_nxt, s_data, s_data_nxt;
  logic [CTRL_W-1:0] h_ctrl, h_ctrl_nxt, s_ctrl, s_ctrl_nxt;
  logic              push;
  logic              pop;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // H is cleared whenever the buffer drains, so it doubles as the bubble output.
  assign out_data  = h_data;
  assign out_ctrl  = h_ctrl;

  // Next-state and storage selection.
  always_comb begin
    state_nxt  = state;
    h_data_nxt = h_data;
    h_ctrl_nxt = h_ctrl;
    s_data_nxt = s_data;
    s_ctrl_nxt = s_ctrl;
    if (flush) begin
      state_nxt  = EMPTY;
      h_data_nxt = {DATA_W{1'b0}};
      h_ctrl_nxt = {CTRL_W{1'b0}};
      s_data_nxt = {DATA_W{1'b0}};
      s_ctrl_nxt = {CTRL_W{1'b0}};
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt  = ONE;
            h_data_nxt = in_data;
            h_ctrl_nxt = in_ctrl;
          end else begin
            state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (push && pop) begin
            h_data_nxt = in_data;
            h_ctrl_nxt = in_ctrl;
          end else if (push) begin
            state_nxt  = FULL;
            s_data_nxt = in_data;
            s_ctrl_nxt = in_ctrl;
          end else if (pop) begin
            state_nxt  = EMPTY;
            h_data_nxt = {DATA_W{1'b0}};
            h_ctrl_nxt = {CTRL_W{1'b0}};
          end else begin
            state_nxt = ONE;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt  = ONE;
            h_data_nxt = s_data;
            h_ctrl_nxt = s_ctrl;
            s_data_nxt = {DATA_W{1'b0}};
            s_ctrl_nxt = {CTRL_W{1'b0}};
          end else begin
            state_nxt = FULL;
          end
        end
        default: begin
          state_nxt  = EMPTY;
          h_data_nxt = {DATA_W{1'b0}};
          h_ctrl_nxt = {CTRL_W{1'b0}};
          s_data_nxt = {DATA_W{1'b0}};
          s_ctrl_nxt = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // State and storage registers, updated on the falling edge like the legacy stage regs.
  always_ff @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state  <= EMPTY;
      h_data <= {DATA_W{1'b0}};
      h_ctrl <= {CTRL_W{1'b0}};
      s_data <= {DATA_W{1'b0}};
      s_ctrl <= {CTRL_W{1'b0}};
    end else begin
      state  <= state_nxt;
      h_data <= h_data_nxt;
      h_ctrl <= h_ctrl_nxt;
      s_data <= s_data_nxt;
      s_ctrl <= s_ctrl_nxt;
    end
  end

  // Saturating backpressure counter; flush deliberately leaves it alone.
  always_ff @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a queue-based reference model tracks
// accepted entries; a monitor compares DUT outputs against it every cycle.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              Resetn = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } entry_t;

  entry_t exp_q[$];
  int     exp_stall = 0;
  int     vectors = 0;
  int     errors = 0;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Resetn(Resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries plus a saturating stall count.
  always @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      exp_q.delete();
      exp_stall = 0;
    end else begin
      automatic int  n       = exp_q.size();
      automatic bit  do_push = in_valid && (n < 2);
      automatic bit  do_pop  = (n > 0) && out_ready;
      if ((n > 0) && !out_ready && (exp_stall < CNT_MAX)) exp_stall++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({in_data, in_ctrl});
      end
    end
  end

  // Monitor: sample on the rising edge, away from the falling active edge.
  always @(posedge CLK) begin
    automatic int     n = exp_q.size();
    automatic entry_t head = (n > 0) ? exp_q[0] : '0;
    chk("out_valid", 64'(out_valid), 64'(n > 0));
    chk("in_ready",  64'(in_ready),  64'(n < 2));
    chk("occupancy", 64'(occupancy), 64'(n));
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    chk("out_ctrl",  64'(out_ctrl),  64'(head.c));
    chk("out_data",  64'(out_data),  64'(head.d));
  end

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    @(posedge CLK);
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    // Reset, then bubble control: in_ctrl all ones but nothing valid.
    repeat (3) drive(1'b0, 32'h0, 8'hFF, 1'b0, 1'b0);
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 32'hDEAD_BEEF, 8'hFF, i[0], 1'b0);

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) drive(1'b1, DATA_W'(i), 8'h5A, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    // Backpressure: third entry held upstream until the skid drains.
    drive(1'b1, 32'h10, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h11, 8'h22, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 32'h12, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 32'h12, 8'h33, 1'b1, 1'b0);
    drive(1'b1, 32'h12, 8'h33, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    // Flush while full with a coincident input that must be discarded.
    drive(1'b1, 32'h20, 8'h44, 1'b0, 1'b0);
    drive(1'b1, 32'h21, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 8'h66, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 32'h0, 8'hFF, 1'b1, 1'b0);

    // Asynchronous reset while full.
    drive(1'b1, 32'hA, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 8'h02, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    @(posedge CLK);
    #2;
    Resetn = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    Resetn = 1'b1;
    drive(1'b1, 32'h33, 8'h77, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    // Saturation: one entry held for 20 stalled edges.
    drive(1'b1, 32'h44, 8'h88, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 60), $urandom, 8'($urandom),
            1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 3));
    end
    drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
